// File: rtl/maxpool_engine_pkg.sv
// Shared types and defaults for the 2x2/stride-2 max-pooling engine.
package maxpool_engine_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 16;
  localparam int MAX_DIM_DEF = 28;
  localparam int DIM_W       = 9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    ISSUE = S_ISSUE,
    DRAIN = S_DRAIN,
    EMIT  = S_EMIT,
    DONE  = S_DONE
  } state_e;

  // An image side is poolable only if it yields at least one output and fits the RAM.
  function automatic logic dim_ok(input logic [DIM_W-1:0] d, input int max_dim);
    return (d >= DIM_W'(2)) && (int'(d) <= max_dim);
  endfunction

endpackage

// File: rtl/maxpool_engine_if.sv
// Image-RAM read port and pooled-pixel output stream of the max-pooling engine.
interface maxpool_engine_if
  import maxpool_engine_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dataout;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  // Handshake: out_data/out_last are meaningful only while out_valid is high; a pixel
  // transfers on a rising edge with out_valid && out_ready, and until then out_valid,
  // out_data and out_last hold. ram_dataout returns the word addressed one cycle earlier.
  modport master (
    output ram_addr,
    input  ram_dataout,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  ram_addr,
    output ram_dataout,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/maxpool_engine_addr_gen.sv
// Window address generator: i/j output counters, row base, k offset and last-pixel flag.
module maxpool_addr_gen
  import maxpool_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DIM_W-1:0]  dim,
  input  logic              k_step,
  input  logic              pix_step,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        k,
  output logic              last_pix
);

  logic [DIM_W-1:0]  i_q, j_q;
  logic [DIM_W-1:0]  p_last;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] dim_a;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] offset;
  logic [1:0]        k_q;

  assign dim_a    = ADDR_W'(dim);
  assign p_last   = (dim >> 1) - DIM_W'(1);
  assign col      = ADDR_W'({j_q, 1'b0});
  assign k        = k_q;
  assign last_pix = (i_q == p_last) && (j_q == p_last);

  always_comb begin
    offset = '0;
    case (k_q)
      2'd0: offset = '0;
      2'd1: offset = ADDR_W'(1);
      2'd2: offset = dim_a;
      2'd3: offset = dim_a + ADDR_W'(1);
      default: offset = '0;
    endcase
  end

  // row_base_q tracks 2*i*dim incrementally, so no multiplier is needed.
  assign addr = row_base_q + col + offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q        <= '0;
      j_q        <= '0;
      row_base_q <= '0;
      k_q        <= '0;
    end else if (clear) begin
      i_q        <= '0;
      j_q        <= '0;
      row_base_q <= '0;
      k_q        <= '0;
    end else begin
      if (k_step) k_q <= k_q + 2'd1;
      if (pix_step) begin
        if (j_q == p_last) begin
          j_q        <= '0;
          i_q        <= i_q + DIM_W'(1);
          row_base_q <= row_base_q + (dim_a << 1);
        end else begin
          j_q <= j_q + DIM_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 max pooling over a dim x dim image held in a shared RAM.
// Control FSM, running-max register and output handshake; addressing lives in maxpool_addr_gen.
module maxpool_engine
  import maxpool_engine_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MAX_DIM = MAX_DIM_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] dim,
  maxpool_engine_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  dim_q;
  logic              bad_q;
  logic [DATA_W-1:0] max_q;
  logic              samp_vld_q;
  logic [1:0]        samp_k_q;

  logic              accept;
  logic              k_step;
  logic              pix_step;
  logic [ADDR_W-1:0] gen_addr;
  logic [1:0]        k;
  logic              last_pix;

  assign accept   = (state_q == IDLE) && start;
  assign k_step   = (state_q == ISSUE) && !bad_q;
  assign pix_step = (state_q == EMIT) && bus.out_ready;

  maxpool_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .dim      (dim_q),
    .k_step   (k_step),
    .pix_step (pix_step),
    .addr     (gen_addr),
    .k        (k),
    .last_pix (last_pix)
  );

  // An unusable dim still passes through one ISSUE cycle, giving done two cycles after start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (bad_q) state_d = DONE;
               else if (k == 2'd3) state_d = DRAIN;
      DRAIN:   state_d = EMIT;
      EMIT:    if (bus.out_ready) state_d = last_pix ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dim_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dim_q <= dim;
        bad_q <= !dim_ok(dim, MAX_DIM);
      end
    end
  end

  // Read data trails the address by one cycle, so remember which k it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_vld_q <= 1'b0;
      samp_k_q   <= '0;
      max_q      <= '0;
    end else begin
      samp_vld_q <= k_step;
      samp_k_q   <= k;
      if (samp_vld_q) begin
        if (samp_k_q == 2'd0) max_q <= bus.ram_dataout;
        else if (bus.ram_dataout > max_q) max_q <= bus.ram_dataout;
      end
    end
  end

  assign bus.ram_addr  = k_step ? gen_addr : '0;
  assign bus.out_data  = max_q;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_last  = (state_q == EMIT) && last_pix;

  assign busy      = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_maxpool_engine.sv
// Self-checking bench for maxpool_engine: RAM model, expected-value queue, scenario tasks.
module tb_maxpool_engine;
  import maxpool_engine_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] dim = '0;
  logic       busy, done;
  logic [2:0] dbg_state;

  maxpool_engine_if #(.DATA_W(8), .ADDR_W(16)) bus ();

  maxpool_engine #(.DATA_W(8), .ADDR_W(16), .MAX_DIM(28)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dim       (dim),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:1023];
  logic [7:0]  exp_q [$];
  logic [15:0] max_addr;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) bus.ram_dataout <= mem[bus.ram_addr[9:0]];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_ramp(input int n);
    for (int a = 0; a < 1024; a++) mem[a] = (a < n) ? 8'(a) : 8'd0;
  endtask

  task automatic push_model(input int d);
    int p;
    logic [7:0] m;
    int b;
    p = d / 2;
    for (int i = 0; i < p; i++) begin
      for (int j = 0; j < p; j++) begin
        b = 2 * i * d + 2 * j;
        m = mem[b];
        if (mem[b + 1] > m) m = mem[b + 1];
        if (mem[b + d] > m) m = mem[b + d];
        if (mem[b + d + 1] > m) m = mem[b + d + 1];
        exp_q.push_back(m);
      end
    end
  endtask

  task automatic start_image(input int d);
    @(posedge clk); #1;
    dim = 9'(d);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Collects n_exp pooled pixels against the queue, then expects the done pulse.
  task automatic drain_image(input int n_exp, input string tag);
    int got = 0;
    int cyc = 0;
    logic [7:0] e;
    max_addr = '0;
    while (got < n_exp && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (bus.ram_addr > max_addr) max_addr = bus.ram_addr;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_output: got %0d, expected none", tag, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            n_fail++;
            $display("FAIL %s pixel%0d: got %0d, expected %0d", tag, got, bus.out_data, e);
          end
        end
        n_checks++;
        if (bus.out_last !== (got == n_exp - 1)) begin
          n_fail++;
          $display("FAIL %s last%0d: got %b, expected %b", tag, got, bus.out_last, got == n_exp - 1);
        end
        got++;
      end
    end
    n_checks++;
    if (got != n_exp) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d outputs, expected %0d", tag, got, n_exp);
    end else begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_pulse: done=%b busy=%b, expected done=1 busy=0", tag, done, busy);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_width: done=%b one cycle later, expected 0", tag, done);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (bus.ram_addr !== 16'd0 || bus.out_data !== 8'd0 || bus.out_valid !== 1'b0 ||
        bus.out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%0d data=%0d valid=%b last=%b busy=%b done=%b, expected all 0",
               bus.ram_addr, bus.out_data, bus.out_valid, bus.out_last, busy, done);
    end
    n_checks++;
    if (dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, expected %0d", dbg_state, S_IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_4x4();
    fill_ramp(16);
    bus.out_ready = 1'b1;
    exp_q.push_back(8'd5);
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd15);
    start_image(4);
    drain_image(4, "img4x4");
  endtask

  task automatic test_odd_5x5();
    fill_ramp(25);
    bus.out_ready = 1'b1;
    exp_q.push_back(8'd6);
    exp_q.push_back(8'd8);
    exp_q.push_back(8'd16);
    exp_q.push_back(8'd18);
    start_image(5);
    drain_image(4, "img5x5");
    n_checks++;
    if (max_addr !== 16'd18) begin
      n_fail++;
      $display("FAIL img5x5 max_addr: got %0d, expected 18", max_addr);
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    fill_ramp(16);
    bus.out_ready = 1'b0;
    exp_q.push_back(8'd5);
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd15);
    start_image(4);
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.out_valid && cyc < 50);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall first_valid: out_valid=%b after %0d cycles, expected 1", bus.out_valid, cyc);
    end
    for (int s = 0; s < 10; s++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd5 || bus.ram_addr !== 16'd0) begin
        n_fail++;
        $display("FAIL stall hold%0d: valid=%b data=%0d addr=%0d, expected 1/5/0",
                 s, bus.out_valid, bus.out_data, bus.ram_addr);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain_image(4, "stall");
  endtask

  task automatic test_invalid_dim(input int d);
    bit seen_valid = 0;
    bus.out_ready = 1'b1;
    start_image(d);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL dim%0d cycle1: busy=%b done=%b, expected busy=1 done=0", d, busy, done);
    end
    if (bus.out_valid) seen_valid = 1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dim%0d done_at_2: done=%b busy=%b, expected done=1 busy=0", d, done, busy);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1;
    end
    n_checks++;
    if (seen_valid) begin
      n_fail++;
      $display("FAIL dim%0d no_output: out_valid seen=1, expected 0", d);
    end
  endtask

  task automatic test_unsigned_2x2();
    bit extra = 0;
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
    mem[0] = 8'd200;
    mem[1] = 8'd255;
    mem[2] = 8'd3;
    mem[3] = 8'd7;
    bus.out_ready = 1'b1;
    exp_q.push_back(8'd255);
    start_image(2);
    @(posedge clk); #1;
    dim = 9'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain_image(1, "img2x2");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy || bus.out_valid) extra = 1;
    end
    n_checks++;
    if (extra) begin
      n_fail++;
      $display("FAIL img2x2 second_start: activity seen=1, expected 0");
    end
  endtask

  task automatic test_reset_mid();
    bit act = 0;
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom_range(0, 255));
    mem[0] = 8'hAB;
    bus.out_ready = 1'b1;
    start_image(28);
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1 || dbg_state !== S_ISSUE) begin
      n_fail++;
      $display("FAIL midreset pre: busy=%b state=%0d, expected 1/%0d", busy, dbg_state, S_ISSUE);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ram_addr !== 16'd0 || bus.out_data !== 8'd0 || bus.out_valid !== 1'b0 ||
        bus.out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset async: addr=%0d data=%0d valid=%b last=%b busy=%b done=%b, expected all 0",
               bus.ram_addr, bus.out_data, bus.out_valid, bus.out_last, busy, done);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy || done || bus.out_valid) act = 1;
    end
    n_checks++;
    if (act) begin
      n_fail++;
      $display("FAIL midreset idle: activity seen=1 before new start, expected 0");
    end
    push_model(28);
    start_image(28);
    drain_image(196, "img28");
  endtask

  initial begin
    bus.out_ready   = 1'b0;
    bus.ram_dataout = '0;
    fill_ramp(0);
    test_reset();
    test_4x4();
    test_odd_5x5();
    test_backpressure();
    test_invalid_dim(1);
    test_invalid_dim(40);
    test_unsigned_2x2();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: %0d entries remain, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_engine.md
MAXPOOL_ENGINE -- requirements
Module: maxpool_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width.
REQ-002 SHALL have parameter ADDR_W, default 16, RAM address width.
REQ-003 SHALL have parameter MAX_DIM, default 28, largest supported image side.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse from the upstream write-back controller: image in RAM is complete.
REQ-007 dim  input  9  image side length, in pixels; image is dim x dim, row-major from address 0.
REQ-008 ram_addr  output  ADDR_W  read address to the shared image RAM.
REQ-009 ram_dataout  input  DATA_W  RAM read data, valid one cycle after ram_addr.
REQ-010 out_data  output  DATA_W  pooled pixel.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both high.
REQ-013 out_last  output  1  high with the final pooled pixel of the image.
REQ-014 busy  output  1  high from the cycle after accepted start until done.
REQ-015 done  output  1  one-cycle pulse on completion of an image.

Function
REQ-016 SHALL compute 2x2 max pooling, stride 2: out(i,j) = max of pixels (2i,2j), (2i,2j+1), (2i+1,2j), (2i+1,2j+1); output side is P = dim>>1.
REQ-017 Odd dim SHALL drop the last row and column; dim < 2 or dim > MAX_DIM SHALL produce no output and SHALL pulse done 2 cycles after start.
REQ-018 SHALL emit pooled pixels in row-major order, P*P in total.
REQ-019 FSM states are IDLE, ISSUE, DRAIN, EMIT and DONE.
REQ-020 IDLE -> ISSUE SHALL occur on start=1; dim SHALL be latched on that edge and SHALL be ignored thereafter.
REQ-021 ISSUE SHALL last 4 cycles, driving addresses k=0..3 = base, base+1, base+dim, base+dim+1, where base = 2i*dim + 2j (ADDR_W-bit arithmetic).
REQ-022 The running max SHALL be initialised to the sample returned for k=0; the samples for k=1..3 SHALL be compared unsigned.
REQ-023 DRAIN SHALL last 1 cycle and SHALL capture the k=3 sample; the state SHALL then go to EMIT.
REQ-024 In EMIT, out_valid SHALL be 1 and out_data SHALL be held stable until out_ready=1.
REQ-025 On handshake, the FSM SHALL go to ISSUE for the next pixel, or to DONE after the last one; best case is 6 cycles per output.
REQ-026 out_last SHALL equal out_valid AND (i = P-1) AND (j = P-1).
REQ-027 DONE SHALL assert done for 1 cycle and SHALL return to IDLE; busy SHALL be 0 in DONE.
REQ-028 start SHALL be ignored while the FSM is not in IDLE.
REQ-029 ram_addr SHALL be 0 outside ISSUE.
REQ-030 out_valid SHALL be 0 outside EMIT.
REQ-031 The j counter SHALL wrap to 0 at P-1 and SHALL increment i.

Reset
REQ-032 When rst_n=0, the FSM SHALL go to IDLE immediately.
REQ-033 During reset, ram_addr=0, out_data=0, out_valid=0, out_last=0, busy=0 and done=0.
REQ-034 Reset mid-image SHALL abandon the image; no partial output SHALL appear after release.
REQ-035 After release, the block SHALL wait for a new start.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, DATA_W/ADDR_W defaults, and MAX_DIM.
REQ-037 A sub-module maxpool_addr_gen SHALL own the i/j counters, base computation, k offset, and last flag.
REQ-038 maxpool_engine SHALL own the FSM, the max register, and the output handshake.

Verification
REQ-039 4x4 image with pixels 0..15, out_ready tied 1 -> outputs 5, 7, 13, 15; out_last on 15; done 1 cycle after the last handshake.
REQ-040 5x5 image with pixels 0..24 -> outputs 6, 8, 16, 18; no address >= 24 issued beyond row 3.
REQ-041 4x4 image with out_ready low 10 cycles during the first EMIT -> out_data=5 held stable throughout, no address issued.
REQ-042 dim=1 and dim=40 -> zero outputs; done pulse 2 cycles after start.
REQ-043 2x2 image with pixels 200, 255, 3, 7 -> output 255 (unsigned compare); second start during busy is ignored.
REQ-044 rst_n pulsed low mid-ISSUE in 28x28 -> all outputs 0 within the reset; no output until a new start, then the full 196-pixel image completes.
